// File: rtl/caliptra_apb_initiator.sv
// APB requester: queued commands on a valid/ready channel drive IDLE/SETUP/ACCESS transfers on the APB pins.
// Optional ACCESS watchdog enabled by defining CALIPTRA_APB_INITIATOR_TIMEOUT_EN.
`ifndef CALIPTRA_APB_ADDR_WIDTH
`define CALIPTRA_APB_ADDR_WIDTH 32
`endif
`ifndef CALIPTRA_APB_DATA_WIDTH
`define CALIPTRA_APB_DATA_WIDTH 32
`endif
`ifndef CALIPTRA_APB_USER_WIDTH
`define CALIPTRA_APB_USER_WIDTH 32
`endif

module caliptra_apb_initiator #(
  parameter int ADDR_W         = `CALIPTRA_APB_ADDR_WIDTH,
  parameter int DATA_W         = `CALIPTRA_APB_DATA_WIDTH,
  parameter int USER_W         = `CALIPTRA_APB_USER_WIDTH,
  parameter int CMD_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [USER_W-1:0] cmd_user,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [2:0]        pprot,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [USER_W-1:0] pauser,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic              busy
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              fifo_write_q [CMD_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [CMD_DEPTH];
  logic [DATA_W-1:0] fifo_wdata_q [CMD_DEPTH];
  logic [USER_W-1:0] fifo_user_q  [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [USER_W-1:0] pauser_q, pauser_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

`ifdef CALIPTRA_APB_INITIATOR_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Ready depends only on the registered count, so a same-cycle pop never bypasses into a push.
  assign cmd_ready = (count_q != CNT_W'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= cmd_write;
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
      fifo_user_q[wr_ptr_q]  <= cmd_user;
    end
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pauser_d      = pauser_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
`ifdef CALIPTRA_APB_INITIATOR_TIMEOUT_EN
    wait_d        = wait_q;
`endif
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Starting only when the response slot is free keeps completions from overwriting.
        if ((count_q != '0) && (!rsp_valid_q || rsp_ready)) begin
          state_d  = ST_SETUP;
          paddr_d  = fifo_addr_q[rd_ptr_q];
          pwrite_d = fifo_write_q[rd_ptr_q];
          pwdata_d = fifo_wdata_q[rd_ptr_q];
          pauser_d = fifo_user_q[rd_ptr_q];
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef CALIPTRA_APB_INITIATOR_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d       = ST_IDLE;
          pop           = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          pwrite_d      = 1'b0;
          pwdata_d      = '0;
        end
`ifdef CALIPTRA_APB_INITIATOR_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_IDLE;
          pop           = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          pwrite_d      = 1'b0;
          pwdata_d      = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pauser_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pauser_q      <= pauser_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

`ifdef CALIPTRA_APB_INITIATOR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

  assign psel        = (state_q != ST_IDLE);
  assign penable     = (state_q == ST_ACCESS);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pauser      = pauser_q;
  assign pprot       = 3'b000;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (count_q != '0) || (state_q != ST_IDLE);

endmodule
